program_memory: RTL and testbench

Parametrised, writable successor to the fixed instruction ROM. Holds the soft-core program in a synchronous block-RAM-style array with a registered read port feeding the fetch stage, a word-wide write port for in-circuit patching, and an optional byte-stream loader so a program can be downloaded over a serial link instead of being recompiled. After every reset it fills itself with a known word before reporting ready.

---
 rtl/program_memory.sv | 234 +++++++++++++++++++++++
 tb/tb_program_memory.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_memory.sv
// ---------------------------------------------------------------------------
// program_memory
//
// Writable instruction store for the soft core. A block-RAM style array with
// a registered read port feeds the fetch stage; a word-wide write port allows
// in-circuit patching. After every reset the array is filled with FILL_WORD,
// one location per cycle, before oReady is raised.
//
// Optional feature macro: PROGRAM_MEMORY_LOADER_EN
//   When defined, a byte-stream loader assembles LSB-first bytes into words
//   and commits them at an auto-incrementing pointer (oLoadPointer).
//
// Ports:
//   Clock, Reset     - rising-edge clock, synchronous active-high reset
//   iAddress         - fetch address (only [ADDR_WIDTH-1:0] used)
//   oInstruction     - registered read data (FILL_WORD while initialising)
//   oReady           - high once the init fill has completed
//   iWriteEnable,
//   iWriteAddress,
//   iWriteData       - word write port (active in RUN only)
//   iLoadStart       - loader restart pulse              (loader build only)
//   iByteValid,iByte - loader byte strobe and byte        (loader build only)
//   oByteReady       - loader can accept a byte           (loader build only)
//   oLoadPointer     - next word address the loader writes (loader build only)
// ---------------------------------------------------------------------------
module program_memory #(
    parameter int                    DATA_WIDTH = 28,
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [15:0]           iAddress,
    output logic [DATA_WIDTH-1:0] oInstruction,
    output logic                  oReady,
`ifdef PROGRAM_MEMORY_LOADER_EN
    input  logic                  iLoadStart,
    input  logic                  iByteValid,
    input  logic [7:0]            iByte,
    output logic                  oByteReady,
    output logic [ADDR_WIDTH-1:0] oLoadPointer,
`endif
    input  logic                  iWriteEnable,
    input  logic [ADDR_WIDTH-1:0] iWriteAddress,
    input  logic [DATA_WIDTH-1:0] iWriteData
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fill_cnt_q, fill_cnt_d;
    logic                    run;

    // Loader commit request, shared with the write arbiter
    logic                    ld_commit;
    logic [ADDR_WIDTH-1:0]   ld_addr;
    logic [DATA_WIDTH-1:0]   ld_data;

    // Array write port (single port, arbitrated below)
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   instr_q;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic                    unused_ok;

    // -----------------------------------------------------------------------
    // INIT/RUN state machine
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= ST_INIT;
            fill_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        if (state_q == ST_INIT) begin
            fill_cnt_d = fill_cnt_q + ADDR_ONE;
            // Leave INIT on the cycle that writes the last location
            if (fill_cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        run = (state_q == ST_RUN);
    end

    assign oReady = run;

    // -----------------------------------------------------------------------
    // Byte loader
    // -----------------------------------------------------------------------
`ifdef PROGRAM_MEMORY_LOADER_EN
    localparam int NBYTES    = (DATA_WIDTH + 7) / 8;
    localparam int WORD_BITS = NBYTES * 8;
    localparam int CNT_W     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0]      byte_cnt_q, byte_cnt_d;
    logic [WORD_BITS-1:0]  word_q, word_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  pending_q, pending_d;
    logic                  byte_ready;
    logic                  byte_accept;
    logic [WORD_BITS-1:0]  word_ins;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            byte_cnt_q <= '0;
            word_q     <= '0;
            ptr_q      <= '0;
            pending_q  <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            ptr_q      <= ptr_d;
            pending_q  <= pending_d;
        end
    end

    always_comb begin
        byte_ready  = run && !pending_q;
        // A byte arriving together with a restart pulse is dropped
        byte_accept = iByteValid && byte_ready && !iLoadStart;

        word_ins = word_q;
        word_ins[{byte_cnt_q, 3'b000} +: 8] = iByte;

        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        ptr_d      = ptr_q;
        pending_d  = pending_q;
        ld_commit  = 1'b0;
        ld_addr    = ptr_q;
        ld_data    = word_q[DATA_WIDTH-1:0];

        if (run && iLoadStart) begin
            // Restart also abandons a word still waiting to commit
            ptr_d      = '0;
            byte_cnt_d = '0;
            pending_d  = 1'b0;
        end else if (pending_q) begin
            // Held word retries on the first cycle the word port is idle
            if (!iWriteEnable) begin
                ld_commit = 1'b1;
                ptr_d     = ptr_q + ADDR_ONE;
                pending_d = 1'b0;
            end
        end else if (byte_accept) begin
            word_d = word_ins;
            if (byte_cnt_q == LAST_BYTE) begin
                byte_cnt_d = '0;
                // Bits above DATA_WIDTH in the last byte fall off here
                ld_data    = word_ins[DATA_WIDTH-1:0];
                if (iWriteEnable) begin
                    pending_d = 1'b1;
                end else begin
                    ld_commit = 1'b1;
                    ptr_d     = ptr_q + ADDR_ONE;
                end
            end else begin
                byte_cnt_d = byte_cnt_q + CNT_ONE;
            end
        end
    end

    assign oByteReady   = byte_ready;
    assign oLoadPointer = ptr_q;
`else
    assign ld_commit = 1'b0;
    assign ld_addr   = '0;
    assign ld_data   = '0;
`endif

    // -----------------------------------------------------------------------
    // Write arbitration: fill in INIT, then word port over loader in RUN
    // -----------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = fill_cnt_q;
        mem_wdata = FILL_WORD;
        if (Reset) begin
            mem_we = 1'b0;
        end else if (!run) begin
            mem_we = 1'b1;
        end else if (iWriteEnable) begin
            mem_we    = 1'b1;
            mem_waddr = iWriteAddress;
            mem_wdata = iWriteData;
        end else if (ld_commit) begin
            mem_we    = 1'b1;
            mem_waddr = ld_addr;
            mem_wdata = ld_data;
        end
    end

    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Registered read port (read-first on a same-address write)
    // -----------------------------------------------------------------------
    assign rd_addr   = iAddress[ADDR_WIDTH-1:0];
    assign unused_ok = ^iAddress;

    always_ff @(posedge Clock) begin
        if (Reset || !run) begin
            instr_q <= FILL_WORD;
        end else begin
            instr_q <= mem[rd_addr];
        end
    end

    assign oInstruction = instr_q;

endmodule

// File: tb/tb_program_memory.sv
// ---------------------------------------------------------------------------
// tb_program_memory
//
// Self-checking bench for program_memory (ADDR_WIDTH=4, FILL_WORD=28'hAA).
// A behavioural model (plain array + loader byte list) predicts every read.
// Loader scenarios are compiled in when PROGRAM_MEMORY_LOADER_EN is defined.
// ---------------------------------------------------------------------------
module tb_program_memory;

    localparam int          DW    = 28;
    localparam int          AW    = 4;
    localparam int          DEPTH = 16;
    localparam logic [27:0] FILL  = 28'h00000AA;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   i_address;
    logic [DW-1:0] o_instruction;
    logic          o_ready;
    logic          i_we;
    logic [AW-1:0] i_waddr;
    logic [DW-1:0] i_wdata;
`ifdef PROGRAM_MEMORY_LOADER_EN
    logic          i_load_start;
    logic          i_byte_valid;
    logic [7:0]    i_byte;
    logic          o_byte_ready;
    logic [AW-1:0] o_load_ptr;
`endif

    always #5 clk = ~clk;

    program_memory #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FILL_WORD  (FILL)
    ) dut (
        .Clock        (clk),
        .Reset        (rst),
        .iAddress     (i_address),
        .oInstruction (o_instruction),
        .oReady       (o_ready),
`ifdef PROGRAM_MEMORY_LOADER_EN
        .iLoadStart   (i_load_start),
        .iByteValid   (i_byte_valid),
        .iByte        (i_byte),
        .oByteReady   (o_byte_ready),
        .oLoadPointer (o_load_ptr),
`endif
        .iWriteEnable (i_we),
        .iWriteAddress(i_waddr),
        .iWriteData   (i_wdata)
    );

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [27:0] ref_mem [DEPTH];
    int          ref_ptr;
    int          ref_cnt;
    logic [7:0]  ref_bytes [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = FILL;
        ref_ptr = 0;
        ref_cnt = 0;
    endtask

    task automatic read_check(input int a, input string tag);
        i_address = {12'($urandom), 4'(a)};
        tick();
        check(tag, 32'(o_instruction), 32'(ref_mem[a]));
    endtask

`ifdef PROGRAM_MEMORY_LOADER_EN
    task automatic model_byte(input logic [7:0] b);
        logic [31:0] w;
        ref_bytes[ref_cnt] = b;
        ref_cnt++;
        if (ref_cnt == 4) begin
            w = {ref_bytes[3], ref_bytes[2], ref_bytes[1], ref_bytes[0]};
            ref_mem[ref_ptr] = w[27:0];
            ref_ptr = (ref_ptr + 1) % DEPTH;
            ref_cnt = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        check("byte_rdy", 32'(o_byte_ready), 32'd1);
        i_byte_valid = 1'b1;
        i_byte       = b;
        tick();
        i_byte_valid = 1'b0;
        model_byte(b);
        check("load_ptr", 32'(o_load_ptr), 32'(ref_ptr));
        if ($urandom_range(0, 3) == 0) tick();
    endtask

    task automatic load_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask
`endif

    initial begin
        logic [31:0] w;
        logic [27:0] exp_rd;
        int          wa;
        int          ra;
        logic        we;

        rst       = 1'b1;
        i_address = '0;
        i_we      = 1'b0;
        i_waddr   = '0;
        i_wdata   = '0;
`ifdef PROGRAM_MEMORY_LOADER_EN
        i_load_start = 1'b0;
        i_byte_valid = 1'b0;
        i_byte       = '0;
`endif
        model_reset();

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_instr", 32'(o_instruction), 32'(FILL));
        check("rst_ready", 32'(o_ready), 32'd0);
`ifdef PROGRAM_MEMORY_LOADER_EN
        check("rst_brdy", 32'(o_byte_ready), 32'd0);
        check("rst_ptr", 32'(o_load_ptr), 32'd0);
`endif

        // ---------------- init fill ----------------
        rst = 1'b0;
        for (int e = 1; e <= DEPTH; e++) begin
            i_address = 16'(e - 1);
            tick();
            check("init_ready", 32'(o_ready), (e == DEPTH) ? 32'd1 : 32'd0);
            check("init_instr", 32'(o_instruction), 32'(FILL));
        end
        for (int a = 0; a < DEPTH; a++) read_check(a, "fill_rd");

        // ---------------- word write, read-first ----------------
        i_we = 1'b1; i_waddr = 4'd5; i_wdata = 28'h1234567; i_address = 16'd5;
        tick();
        check("rd_first", 32'(o_instruction), 32'h00000AA);
        i_we = 1'b0;
        ref_mem[5] = 28'h1234567;
        tick();
        check("rd_after_wr", 32'(o_instruction), 32'h1234567);

        // ---------------- randomized word port traffic ----------------
        for (int k = 0; k < 200; k++) begin
            we = 1'($urandom_range(0, 1));
            wa = $urandom_range(0, DEPTH - 1);
            ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH - 1);
            w  = $urandom;
            i_we      = we;
            i_waddr   = 4'(wa);
            i_wdata   = w[27:0];
            i_address = {12'($urandom), 4'(ra)};
            exp_rd    = ref_mem[ra];
            tick();
            check("rand_rd", 32'(o_instruction), 32'(exp_rd));
            if (we) ref_mem[wa] = w[27:0];
        end
        i_we = 1'b0;

`ifdef PROGRAM_MEMORY_LOADER_EN
        // ---------------- loader basic word ----------------
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
        ref_ptr = 0; ref_cnt = 0;
        check("ls_ptr", 32'(o_load_ptr), 32'd0);
        send_byte(8'h67); send_byte(8'h45); send_byte(8'h23); send_byte(8'hF1);
        check("ld_ptr1", 32'(o_load_ptr), 32'd1);
        i_address = 16'd0;
        tick();
        check("ld_word0", 32'(o_instruction), 32'h1234567);

        // ---------------- commit vs word port conflict ----------------
        w = $urandom;
        send_byte(w[7:0]); send_byte(w[15:8]); send_byte(w[23:16]);
        i_byte_valid = 1'b1; i_byte = w[31:24];
        i_we = 1'b1; i_waddr = 4'd3; i_wdata = 28'h0BEEF03;
        tick();
        ref_mem[3] = 28'h0BEEF03;
        check("cf_brdy_low", 32'(o_byte_ready), 32'd0);
        check("cf_ptr_hold", 32'(o_load_ptr), 32'd1);
        // Byte offered while the commit is pending must be ignored
        i_we = 1'b0; i_byte = 8'h55;
        tick();
        i_byte_valid = 1'b0;
        model_byte(w[31:24]);
        check("cf_brdy_back", 32'(o_byte_ready), 32'd1);
        check("cf_ptr_inc", 32'(o_load_ptr), 32'd2);
        read_check(3, "cf_port_word");
        read_check(1, "cf_ld_word");

        // ---------------- restart with coincident byte, then wrap ----------------
        send_byte(8'h9C);
        i_load_start = 1'b1; i_byte_valid = 1'b1; i_byte = 8'hEE;
        tick();
        i_load_start = 1'b0; i_byte_valid = 1'b0;
        ref_ptr = 0; ref_cnt = 0;
        check("ls2_ptr", 32'(o_load_ptr), 32'd0);
        for (int wi = 0; wi < 17; wi++) begin
            load_word($urandom);
            if (wi == 15) check("wrap_ptr", 32'(o_load_ptr), 32'd0);
        end
        for (int a = 0; a < DEPTH; a++) read_check(a, "wrap_rd");

        // partial word before reset
        send_byte(8'h11); send_byte(8'h22);
`endif

        // ---------------- reset mid-load and mid-INIT ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check("rr_ready", 32'(o_ready), 32'd0);
        check("rr_instr", 32'(o_instruction), 32'(FILL));
        for (int e = 0; e < 5; e++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int e = 1; e <= DEPTH; e++) begin
            // Word port and loader traffic during INIT must be ignored
            i_we    = (e >= 5 && e <= 8);
            i_waddr = 4'd0;
            i_wdata = 28'h1111111;
`ifdef PROGRAM_MEMORY_LOADER_EN
            i_byte_valid = 1'b1;
            i_byte       = 8'h77;
            check("ri_brdy", 32'(o_byte_ready), 32'd0);
`endif
            tick();
            check("ri_ready", 32'(o_ready), (e == DEPTH) ? 32'd1 : 32'd0);
        end
        i_we = 1'b0;
`ifdef PROGRAM_MEMORY_LOADER_EN
        i_byte_valid = 1'b0;
        check("ri_ptr", 32'(o_load_ptr), 32'd0);
`endif
        for (int a = 0; a < DEPTH; a++) read_check(a, "ri_fill_rd");
`ifdef PROGRAM_MEMORY_LOADER_EN
        load_word(32'hF7654321);
        i_address = 16'd0;
        tick();
        check("ri_ld_word", 32'(o_instruction), 32'h7654321);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
